// File: rtl/onfi_pkg.sv
// Shared encodings and default timing for the ONFI SDR host sequencer, target model and bench.
package onfi_pkg;

  typedef enum logic [1:0] {
    OP_CMD  = 2'd0,
    OP_ADDR = 2'd1,
    OP_DOUT = 2'd2,
    OP_DIN  = 2'd3
  } op_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrbLo,
    StStrbHi,
    StWbWait,
    StRbWait
  } seq_state_e;

  localparam int unsigned T_WP_DEF   = 2;
  localparam int unsigned T_WH_DEF   = 2;
  localparam int unsigned T_WB_DEF   = 4;
  localparam int unsigned RB_TMO_DEF = 1024;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/onfi_sync2.sv
// Two-flop synchroniser for a single asynchronous level, with selectable reset value.
module onfi_sync2 #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/onfi_host_sdr_seq.sv
// Host-side ONFI SDR (asynchronous mode) byte sequencer: one CMD/ADDR/DOUT/DIN cycle per
// request, optional tWB + R/B_n wait with timeout. All pin outputs are registered.
module onfi_host_sdr_seq
  import onfi_pkg::*;
#(
  parameter int unsigned T_WP   = T_WP_DEF,
  parameter int unsigned T_WH   = T_WH_DEF,
  parameter int unsigned T_WB   = T_WB_DEF,
  parameter int unsigned RB_TMO = RB_TMO_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [1:0] op_type,
  input  logic [7:0] op_data,
  input  logic       op_wait_rb,
  input  logic       op_last,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rb_tmo,
  output logic       ce_n,
  output logic       cle,
  output logic       ale,
  output logic       we_n,
  output logic       re_n,
  output logic [7:0] io_out,
  output logic       io_oe,
  input  logic [7:0] io_in,
  input  logic       rb_n
);

  localparam int unsigned CntMax = max4(T_WP, T_WH, T_WB, RB_TMO);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t WpEnd  = cnt_t'(T_WP - 1);
  localparam cnt_t WhEnd  = cnt_t'(T_WH - 1);
  localparam cnt_t WbEnd  = cnt_t'(T_WB - 1);
  localparam cnt_t TmoEnd = cnt_t'(RB_TMO - 1);

  seq_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  cnt_t       cnt_end;
  logic       cnt_done;
  op_type_e   type_q, type_d;
  op_type_e   op_sel;
  logic       wait_q, wait_d;
  logic       last_q, last_d;
  logic       ce_n_q, ce_n_d;
  logic       cle_q, cle_d;
  logic       ale_q, ale_d;
  logic       we_n_q, we_n_d;
  logic       re_n_q, re_n_d;
  logic [7:0] io_out_q, io_out_d;
  logic       io_oe_q, io_oe_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rb_tmo_q, rb_tmo_d;
  logic       ready_q, ready_d;
  logic       accept;
  logic       rb_s;

  onfi_sync2 #(
    .ResetVal (1'b1)
  ) u_rb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rb_n),
    .q     (rb_s)
  );

  assign op_sel   = op_type_e'(op_type);
  assign accept   = op_valid & ready_q;
  assign cnt_done = (cnt_q == cnt_end);

  always_comb begin
    unique case (state_q)
      StStrbLo: cnt_end = WpEnd;
      StStrbHi: cnt_end = WhEnd;
      StWbWait: cnt_end = WbEnd;
      StRbWait: cnt_end = TmoEnd;
      default:  cnt_end = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      type_q     <= OP_CMD;
      wait_q     <= 1'b0;
      last_q     <= 1'b0;
      ce_n_q     <= 1'b1;
      cle_q      <= 1'b0;
      ale_q      <= 1'b0;
      we_n_q     <= 1'b1;
      re_n_q     <= 1'b1;
      io_out_q   <= 8'h00;
      io_oe_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      rb_tmo_q   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      type_q     <= type_d;
      wait_q     <= wait_d;
      last_q     <= last_d;
      ce_n_q     <= ce_n_d;
      cle_q      <= cle_d;
      ale_q      <= ale_d;
      we_n_q     <= we_n_d;
      re_n_q     <= re_n_d;
      io_out_q   <= io_out_d;
      io_oe_q    <= io_oe_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rb_tmo_q   <= rb_tmo_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  state_d = StStrbLo;
      StStrbLo: if (cnt_done) state_d = StStrbHi;
      StStrbHi: if (cnt_done) state_d = wait_q ? StWbWait : StIdle;
      StWbWait: if (cnt_done) state_d = StRbWait;
      StRbWait: if (rb_s || cnt_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Counter restarts from zero on every state entry and saturates rather than wrapping.
    if (state_d != state_q || state_q == StIdle) begin
      cnt_d = '0;
    end else if (cnt_q == {CntW{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    type_d     = type_q;
    wait_d     = wait_q;
    last_d     = last_q;
    ce_n_d     = ce_n_q;
    cle_d      = cle_q;
    ale_d      = ale_q;
    we_n_d     = we_n_q;
    re_n_d     = re_n_q;
    io_out_d   = io_out_q;
    io_oe_d    = io_oe_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rb_tmo_d   = 1'b0;
    ready_d    = (state_d == StIdle);
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          type_d  = op_sel;
          wait_d  = op_wait_rb;
          last_d  = op_last;
          ce_n_d  = 1'b0;
          cle_d   = (op_sel == OP_CMD);
          ale_d   = (op_sel == OP_ADDR);
          io_oe_d = (op_sel != OP_DIN);
          if (op_sel != OP_DIN) io_out_d = op_data;
        end
      end
      StSetup: begin
        if (type_q == OP_DIN) re_n_d = 1'b0;
        else                  we_n_d = 1'b0;
      end
      StStrbLo: begin
        if (cnt_done) begin
          we_n_d = 1'b1;
          re_n_d = 1'b1;
          if (type_q == OP_DIN) begin
            rd_data_d  = io_in;
            rd_valid_d = 1'b1;
          end
        end
      end
      StStrbHi: begin
        if (cnt_done) begin
          cle_d   = 1'b0;
          ale_d   = 1'b0;
          io_oe_d = 1'b0;
          if (!wait_q && last_q) ce_n_d = 1'b1;
        end
      end
      StWbWait: ;
      StRbWait: begin
        if (rb_s) begin
          if (last_q) ce_n_d = 1'b1;
        end else if (cnt_done) begin
          rb_tmo_d = 1'b1;
          ce_n_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign op_ready = ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rb_tmo   = rb_tmo_q;
  assign ce_n     = ce_n_q;
  assign cle      = cle_q;
  assign ale      = ale_q;
  assign we_n     = we_n_q;
  assign re_n     = re_n_q;
  assign io_out   = io_out_q;
  assign io_oe    = io_oe_q;

endmodule

// File: tb/tb_onfi_host_sdr_seq.sv
// Directed bench for onfi_host_sdr_seq with a simple read-data target model on io_in / rb_n.
module tb_onfi_host_sdr_seq;
  import onfi_pkg::*;

  localparam int unsigned KRdy = 1 + T_WP_DEF + T_WH_DEF;  // edges to op_ready, no wait
  localparam int unsigned KRb  = KRdy + T_WB_DEF;           // edge entering R/B_n wait
  localparam int unsigned KTmo = KRb + RB_TMO_DEF;          // edge raising rb_tmo

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op_type;
  logic [7:0] op_data;
  logic       op_wait_rb;
  logic       op_last;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rb_tmo;
  logic       ce_n;
  logic       cle;
  logic       ale;
  logic       we_n;
  logic       re_n;
  logic [7:0] io_out;
  logic       io_oe;
  logic [7:0] io_in;
  logic       rb_n;

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [7:0] rd_bytes [4];
  int         rd_idx = 0;
  int         hi_run = 0;
  int         gap    = 0;

  onfi_host_sdr_seq u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_type    (op_type),
    .op_data    (op_data),
    .op_wait_rb (op_wait_rb),
    .op_last    (op_last),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rb_tmo     (rb_tmo),
    .ce_n       (ce_n),
    .cle        (cle),
    .ale        (ale),
    .we_n       (we_n),
    .re_n       (re_n),
    .io_out     (io_out),
    .io_oe      (io_oe),
    .io_in      (io_in),
    .rb_n       (rb_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Target model: drives the next ID byte while RE_n is low, advances on RE_n rising.
  assign io_in = (!re_n && rd_idx < 4) ? rd_bytes[rd_idx] : 8'h00;
  always @(posedge re_n) if (ce_n === 1'b0) rd_idx <= rd_idx + 1;

  // Length of the WE_n-high run preceding the most recent WE_n fall.
  always @(negedge clk) begin
    if (we_n === 1'b1) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run != 0) gap <= hi_run;
      hi_run <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept_op(input logic [1:0] t, input logic [7:0] d, input logic w,
                           input logic l, input string tag);
    op_type    = t;
    op_data    = d;
    op_wait_rb = w;
    op_last    = l;
    op_valid   = 1'b1;
    for (int i = 0; i < 4000 && !op_ready; i++) @(negedge clk);
    check({tag, " accept"}, 32'(op_ready), 32'd1);
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  // No-wait op; checks the pins after each of the KRdy+1 edges from acceptance.
  task automatic run_op(input logic [1:0] t, input logic [7:0] d, input logic l,
                        input logic [7:0] exp_rd, input string tag);
    logic strb;
    logic held;
    accept_op(t, d, 1'b0, l, tag);
    for (int k = 0; k <= int'(KRdy); k++) begin
      @(negedge clk);
      strb = (k >= 1 && k <= int'(T_WP_DEF));
      held = (k < int'(KRdy));
      check($sformatf("%s k%0d ce_n", tag, k), 32'(ce_n), (k == int'(KRdy)) ? 32'(l) : 32'd0);
      check($sformatf("%s k%0d cle", tag, k), 32'(cle), 32'(held && t == OP_CMD));
      check($sformatf("%s k%0d ale", tag, k), 32'(ale), 32'(held && t == OP_ADDR));
      check($sformatf("%s k%0d io_oe", tag, k), 32'(io_oe), 32'(held && t != OP_DIN));
      check($sformatf("%s k%0d we_n", tag, k), 32'(we_n), 32'(!(strb && t != OP_DIN)));
      check($sformatf("%s k%0d re_n", tag, k), 32'(re_n), 32'(!(strb && t == OP_DIN)));
      check($sformatf("%s k%0d op_ready", tag, k), 32'(op_ready), 32'(k == int'(KRdy)));
      check($sformatf("%s k%0d rd_valid", tag, k), 32'(rd_valid),
            32'(k == int'(T_WP_DEF) + 1 && t == OP_DIN));
      if (t != OP_DIN && held) check($sformatf("%s k%0d io_out", tag, k), 32'(io_out), 32'(d));
      if (t == OP_DIN && k == int'(T_WP_DEF) + 1)
        check($sformatf("%s rd_data", tag), 32'(rd_data), 32'(exp_rd));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_miss);
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    op_valid   = 1'b0;
    op_type    = 2'd0;
    op_data    = 8'h00;
    op_wait_rb = 1'b0;
    op_last    = 1'b0;
    rb_n       = 1'b1;
    rd_bytes   = '{8'h2C, 8'h68, 8'h04, 8'h4A};

    // Reset state, then op_ready after the first edge past release.
    repeat (2) @(negedge clk);
    check("reset pins", 32'({ce_n, cle, ale, we_n, re_n, io_oe, io_out, rd_valid, rd_data,
                             rb_tmo, op_ready}),
          32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0}));
    rst_n = 1'b1;
    #1 check("ready before first edge", 32'(op_ready), 32'd0);
    @(negedge clk);
    check("ready after release", 32'(op_ready), 32'd1);

    // CMD 0xFF with R/B_n wait; R/B_n low from inside tWB for 20 clk.
    accept_op(OP_CMD, 8'hFF, 1'b1, 1'b1, "reset_cmd");
    for (int k = 0; k <= 28; k++) begin
      @(negedge clk);
      if (k == int'(KRdy)) rb_n = 1'b0;
      if (k == 25) rb_n = 1'b1;  // first sampled at edge 26, FSM sees it at edge 28
      if (k < int'(KRdy)) begin
        check($sformatf("ff k%0d cle", k), 32'(cle), 32'd1);
        check($sformatf("ff k%0d io_out", k), 32'(io_out), 32'hFF);
      end
      if (k <= int'(KRdy))
        check($sformatf("ff k%0d we_n", k), 32'(we_n), 32'(!(k >= 1 && k <= int'(T_WP_DEF))));
      if (k == int'(KRdy)) check("ff cle dropped", 32'(cle), 32'd0);
      if ((k >= int'(KRdy) && k <= int'(KRb)) || k == 27)
        check($sformatf("ff k%0d busy", k), 32'(op_ready), 32'd0);
      if (k == 28) begin
        check("ff ready after rb", 32'(op_ready), 32'd1);
        check("ff ce_n released", 32'(ce_n), 32'd1);
      end else begin
        check($sformatf("ff k%0d ce_n", k), 32'(ce_n), 32'd0);
      end
    end

    // Read ID: CMD 0x90, ADDR 0x00, four DIN bytes from the target.
    rd_idx = 0;
    run_op(OP_CMD, 8'h90, 1'b0, 8'h00, "rid_cmd");
    run_op(OP_ADDR, 8'h00, 1'b0, 8'h00, "rid_addr");
    run_op(OP_DIN, 8'h00, 1'b0, 8'h2C, "rid_b0");
    run_op(OP_DIN, 8'h00, 1'b0, 8'h68, "rid_b1");
    run_op(OP_DIN, 8'h00, 1'b0, 8'h04, "rid_b2");
    run_op(OP_DIN, 8'h00, 1'b1, 8'h4A, "rid_b3");

    // DOUT directly after ADDR: WE_n high T_WH + IDLE + SETUP between falls.
    run_op(OP_ADDR, 8'h12, 1'b0, 8'h00, "dly_addr");
    run_op(OP_DOUT, 8'hA5, 1'b1, 8'h00, "dly_dout");
    check("we_n high gap", 32'(gap), 32'(T_WH_DEF + 2));

    // op_valid held high with op_data changing while busy.
    op_type    = OP_DOUT;
    op_data    = 8'h3C;
    op_wait_rb = 1'b0;
    op_last    = 1'b0;
    op_valid   = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= int'(KRdy); k++) begin
      @(negedge clk);
      if (k < int'(KRdy)) begin
        check($sformatf("hold k%0d io_out", k), 32'(io_out), 32'h3C);
        op_data = 8'hE0 + 8'(k);
      end else begin
        check("hold ready", 32'(op_ready), 32'd1);
        op_data = 8'h5A;
        op_last = 1'b1;
      end
    end
    @(posedge clk);
    #1 op_valid = 1'b0;
    op_data = 8'h77;
    @(negedge clk);
    check("hold second byte", 32'(io_out), 32'h5A);
    for (int i = 0; i < 50 && !op_ready; i++) @(negedge clk);
    check("hold done ce_n", 32'(ce_n), 32'd1);

    // R/B_n stuck low: timeout pulse exactly RB_TMO cycles into the wait.
    rb_n = 1'b0;
    repeat (3) @(negedge clk);
    accept_op(OP_CMD, 8'h70, 1'b1, 1'b0, "tmo");
    for (int k = 0; k <= int'(KTmo) + 1; k++) begin
      @(negedge clk);
      if (k == int'(KTmo) - 1) begin
        check("tmo early", 32'(rb_tmo), 32'd0);
        check("tmo busy", 32'(op_ready), 32'd0);
        check("tmo ce_n low", 32'(ce_n), 32'd0);
      end
      if (k == int'(KTmo)) check("tmo pulse", 32'(rb_tmo), 32'd1);
      if (k == int'(KTmo) + 1) begin
        check("tmo one cycle", 32'(rb_tmo), 32'd0);
        check("tmo ce_n", 32'(ce_n), 32'd1);
        check("tmo ready", 32'(op_ready), 32'd1);
      end
    end
    rb_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset while WE_n is low during a DOUT.
    accept_op(OP_DOUT, 8'hA5, 1'b0, 1'b0, "mid_rst");
    repeat (2) @(negedge clk);
    check("mid_rst we_n low", 32'(we_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst pins", 32'({ce_n, cle, ale, we_n, re_n, io_oe, io_out, rd_data, op_ready}),
          32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst ready", 32'(op_ready), 32'd1);
    run_op(OP_DOUT, 8'h3C, 1'b1, 8'h00, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
